// File: rtl/lcd_timing_pkg.sv
// Purpose : shared LCD raster timing defaults, sync window bounds and pixel type.
// Latency : n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package lcd_timing_pkg;

    // Default panel timing (480x272 class panel).
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 43;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 8;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 12;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_RD_LAT   = 2;

    // Sync pulses span [START, END) in counter units (clocks for H, lines for V).
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Idle value of the {hs, vs, den} control bundle: syncs inactive (high), den low.
    localparam logic [2:0] CTRL_IDLE = 3'b110;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // True when lo <= pos < hi.
    function automatic logic in_window(input logic [10:0] pos,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/lcd_ctrl_delay.sv
// Purpose : DEPTH-stage shift register for the {hs, vs, den} control bundle.
// Latency : DEPTH clocks from ctrl_i to ctrl_o.
// Backpressure: none, shifts every clock. Ports: clk_i, reset_i (sync, high), ctrl_i/ctrl_o {hs,vs,den}.
module lcd_ctrl_delay
    import lcd_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] ctrl_i,
    output logic [2:0] ctrl_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("lcd_ctrl_delay: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0][2:0] sr_q;
    logic [DEPTH-1:0][2:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = ctrl_i;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q <= {DEPTH{CTRL_IDLE}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ctrl_o = sr_q[DEPTH-1];

endmodule

// File: rtl/lcd_panel_timing_gen.sv
// Purpose : LCD raster generator: H/V counters, line-buffer read requests, HSYNC/VSYNC/DEN and RGB pins.
// Latency : counter -> rd_* 1 clock; counter -> lcd_* pins RD_LAT+2 clocks (pixel data sampled RD_LAT after rd_en).
// Backpressure: none; enable_i low holds counters at 0 and lets the pin pipeline drain to idle.
// Ports: clk_i/reset_i/enable_i control; hcount_o/vcount_o raw counters; rd_en_o/rd_x_o/rd_y_o line-buffer
//        read; pix_*_i line-buffer data; frame_start_o/line_start_o pulses; lcd_* panel pins.
module lcd_panel_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    output logic [10:0] hcount_o,
    output logic [10:0] vcount_o,
    output logic        rd_en_o,
    output logic [9:0]  rd_x_o,
    output logic [8:0]  rd_y_o,
    input  logic [4:0]  pix_r_i,
    input  logic [5:0]  pix_g_i,
    input  logic [4:0]  pix_b_i,
    output logic        frame_start_o,
    output logic        line_start_o,
    output logic        lcd_hsync_o,
    output logic        lcd_vsync_o,
    output logic        lcd_den_o,
    output logic [4:0]  lcd_r_o,
    output logic [5:0]  lcd_g_o,
    output logic [4:0]  lcd_b_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_LO  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_HI  = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL >= 2048 || V_TOTAL >= 2048 || H_ACTIVE > 1024 || V_ACTIVE > 512 ||
        RD_LAT < 1 || RD_LAT > 4) begin : g_bad_params
        $error("lcd_panel_timing_gen: timing parameters out of range");
    end

    // ------------------------------------------------------------------
    // Counter stage
    // ------------------------------------------------------------------
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (!enable_i) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end else begin
            hcount_d = hcount_q + 11'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: decode counters into read request and raw control.
    // While disabled every decode is forced idle so the downstream
    // pipeline drains to sync-high / den-low on its own.
    // ------------------------------------------------------------------
    logic       active;
    logic       rd_en_q, rd_en_d;
    logic [9:0] rd_x_q, rd_x_d;
    logic [8:0] rd_y_q, rd_y_d;
    logic       frame_start_q, frame_start_d;
    logic       line_start_q, line_start_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;

    always_comb begin
        active        = enable_i && (hcount_q < H_ACT) && (vcount_q < V_ACT);
        rd_en_d       = active;
        // Coordinates hold their last value outside the active window.
        rd_x_d        = active ? hcount_q[9:0] : rd_x_q;
        rd_y_d        = active ? vcount_q[8:0] : rd_y_q;
        frame_start_d = enable_i && (hcount_q == 11'd0) && (vcount_q == 11'd0);
        line_start_d  = enable_i && (hcount_q == 11'd0);
        hs_raw_d      = !(enable_i && in_window(hcount_q, HS_LO, HS_HI));
        vs_raw_d      = !(enable_i && in_window(vcount_q, VS_LO, VS_HI));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_en_q       <= 1'b0;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            hs_raw_q      <= 1'b1;
            vs_raw_q      <= 1'b1;
        end else begin
            rd_en_q       <= rd_en_d;
            rd_x_q        <= rd_x_d;
            rd_y_q        <= rd_y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
        end
    end

    // ------------------------------------------------------------------
    // Control delay: RD_LAT stages line the control bundle up with the
    // line-buffer data; the pin register below adds the final clock.
    // ------------------------------------------------------------------
    logic [2:0] ctrl_dly;

    lcd_ctrl_delay #(
        .DEPTH (RD_LAT)
    ) u_ctrl_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ctrl_i  ({hs_raw_q, vs_raw_q, rd_en_q}),
        .ctrl_o  (ctrl_dly)
    );

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic    lcd_hsync_q, lcd_hsync_d;
    logic    lcd_vsync_q, lcd_vsync_d;
    logic    lcd_den_q, lcd_den_d;
    rgb565_t lcd_rgb_q, lcd_rgb_d;
    rgb565_t pix;

    always_comb begin
        pix         = '{r: pix_r_i, g: pix_g_i, b: pix_b_i};
        lcd_hsync_d = ctrl_dly[2];
        lcd_vsync_d = ctrl_dly[1];
        lcd_den_d   = ctrl_dly[0];
        // Blank the bus outside the data-enable window.
        lcd_rgb_d   = ctrl_dly[0] ? pix : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lcd_hsync_q <= 1'b1;
            lcd_vsync_q <= 1'b1;
            lcd_den_q   <= 1'b0;
            lcd_rgb_q   <= '0;
        end else begin
            lcd_hsync_q <= lcd_hsync_d;
            lcd_vsync_q <= lcd_vsync_d;
            lcd_den_q   <= lcd_den_d;
            lcd_rgb_q   <= lcd_rgb_d;
        end
    end

    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign rd_en_o       = rd_en_q;
    assign rd_x_o        = rd_x_q;
    assign rd_y_o        = rd_y_q;
    assign frame_start_o = frame_start_q;
    assign line_start_o  = line_start_q;
    assign lcd_hsync_o   = lcd_hsync_q;
    assign lcd_vsync_o   = lcd_vsync_q;
    assign lcd_den_o     = lcd_den_q;
    assign lcd_r_o       = lcd_rgb_q.r;
    assign lcd_g_o       = lcd_rgb_q.g;
    assign lcd_b_o       = lcd_rgb_q.b;

endmodule

// File: tb/tb_lcd_panel_timing_gen.sv
// Bench for lcd_panel_timing_gen: three instances share clock, reset and enable.
//   d0: default timing, RD_LAT=2     d1: default timing, RD_LAT=4
//   ds: shrunken raster (24x12 totals, RD_LAT=3) so whole frames fit in a short run.
module tb_lcd_panel_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic en;

    int tests = 0;
    int fails = 0;

    // d0 signals
    logic [10:0] hc0, vc0;
    logic        rde0, fs0, ls0, hs0, vs0, den0;
    logic [9:0]  rx0;
    logic [8:0]  ry0;
    logic [4:0]  pr0, pb0, r0, b0;
    logic [5:0]  pg0, g0;
    // d1 signals
    logic [10:0] hc1, vc1;
    logic        rde1, fs1, ls1, hs1, vs1, den1;
    logic [9:0]  rx1;
    logic [8:0]  ry1;
    logic [4:0]  pr1, pb1, r1, b1;
    logic [5:0]  pg1, g1;
    // ds signals
    logic [10:0] hcs, vcs;
    logic        rdes, fss, lss, hss, vss, dens;
    logic [9:0]  rxs;
    logic [8:0]  rys;
    logic [4:0]  prs, pbs, rs, bs;
    logic [5:0]  pgs, gs;

    lcd_panel_timing_gen d0 (
        .clk_i(clk), .reset_i(reset), .enable_i(en),
        .hcount_o(hc0), .vcount_o(vc0), .rd_en_o(rde0), .rd_x_o(rx0), .rd_y_o(ry0),
        .pix_r_i(pr0), .pix_g_i(pg0), .pix_b_i(pb0),
        .frame_start_o(fs0), .line_start_o(ls0),
        .lcd_hsync_o(hs0), .lcd_vsync_o(vs0), .lcd_den_o(den0),
        .lcd_r_o(r0), .lcd_g_o(g0), .lcd_b_o(b0)
    );

    lcd_panel_timing_gen #(.RD_LAT(4)) d1 (
        .clk_i(clk), .reset_i(reset), .enable_i(en),
        .hcount_o(hc1), .vcount_o(vc1), .rd_en_o(rde1), .rd_x_o(rx1), .rd_y_o(ry1),
        .pix_r_i(pr1), .pix_g_i(pg1), .pix_b_i(pb1),
        .frame_start_o(fs1), .line_start_o(ls1),
        .lcd_hsync_o(hs1), .lcd_vsync_o(vs1), .lcd_den_o(den1),
        .lcd_r_o(r1), .lcd_g_o(g1), .lcd_b_o(b1)
    );

    lcd_panel_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .RD_LAT(3)
    ) ds (
        .clk_i(clk), .reset_i(reset), .enable_i(en),
        .hcount_o(hcs), .vcount_o(vcs), .rd_en_o(rdes), .rd_x_o(rxs), .rd_y_o(rys),
        .pix_r_i(prs), .pix_g_i(pgs), .pix_b_i(pbs),
        .frame_start_o(fss), .line_start_o(lss),
        .lcd_hsync_o(hss), .lcd_vsync_o(vss), .lcd_den_o(dens),
        .lcd_r_o(rs), .lcd_g_o(gs), .lcd_b_o(bs)
    );

    // Line-buffer models: colour {x[4:0], y[5:0], ~x[4:0]} returned RD_LAT clocks after the request.
    logic [15:0] lb0 [2];
    logic [15:0] lb1 [4];
    logic [15:0] lbs [3];

    always @(posedge clk) begin
        lb0[0] <= {rx0[4:0], ry0[5:0], ~rx0[4:0]};
        lb0[1] <= lb0[0];
        lb1[0] <= {rx1[4:0], ry1[5:0], ~rx1[4:0]};
        for (int i = 1; i < 4; i++) lb1[i] <= lb1[i-1];
        lbs[0] <= {rxs[4:0], rys[5:0], ~rxs[4:0]};
        for (int i = 1; i < 3; i++) lbs[i] <= lbs[i-1];
    end

    assign {pr0, pg0, pb0} = lb0[1];
    assign {pr1, pg1, pb1} = lb1[3];
    assign {prs, pgs, pbs} = lbs[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string nm,
                            input logic [10:0] hc, input logic [10:0] vc, input logic rde,
                            input logic [9:0] rx, input logic [8:0] ry, input logic fs, input logic ls,
                            input logic hs, input logic vs, input logic den,
                            input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        chk({nm, " hcount"}, 32'(hc), 0);
        chk({nm, " vcount"}, 32'(vc), 0);
        chk({nm, " rd_en"}, 32'(rde), 0);
        chk({nm, " rd_x"}, 32'(rx), 0);
        chk({nm, " rd_y"}, 32'(ry), 0);
        chk({nm, " frame_start"}, 32'(fs), 0);
        chk({nm, " line_start"}, 32'(ls), 0);
        chk({nm, " hsync"}, 32'(hs), 1);
        chk({nm, " vsync"}, 32'(vs), 1);
        chk({nm, " den"}, 32'(den), 0);
        chk({nm, " rgb"}, {16'd0, r, g, b}, 0);
    endtask

    // Expected outputs at cycle n of a run that started with counters at (0,0) in cycle 0
    // and an idle pin pipeline.
    task automatic check_inst(input string nm, input int n,
                              input int HA, input int HF, input int HS, input int HB,
                              input int VA, input int VF, input int VS, input int VB, input int LAT,
                              input logic [10:0] hc, input logic [10:0] vc, input logic rde,
                              input logic [9:0] rx, input logic [8:0] ry, input logic fs, input logic ls,
                              input logic hs, input logic vs, input logic den,
                              input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        int    ht, vt, h1, v1, q, h2, v2, rxe, rye;
        bit    act, den_e, hs_e, vs_e;
        int    re, ge, be;
        string p;
        ht = HA + HF + HS + HB;
        vt = VA + VF + VS + VB;
        p  = $sformatf("%s n=%0d", nm, n);
        chk({p, " hcount"}, 32'(hc), 32'(n % ht));
        chk({p, " vcount"}, 32'(vc), 32'((n / ht) % vt));
        h1  = (n - 1) % ht;
        v1  = ((n - 1) / ht) % vt;
        act = (h1 < HA) && (v1 < VA);
        if (act) begin
            rxe = h1;     rye = v1;
        end else if (v1 < VA) begin
            rxe = HA - 1; rye = v1;
        end else begin
            rxe = HA - 1; rye = VA - 1;
        end
        chk({p, " rd_en"}, 32'(rde), 32'(act));
        chk({p, " rd_x"}, 32'(rx), 32'(rxe));
        chk({p, " rd_y"}, 32'(ry), 32'(rye));
        chk({p, " frame_start"}, 32'(fs), 32'(h1 == 0 && v1 == 0));
        chk({p, " line_start"}, 32'(ls), 32'(h1 == 0));
        q = n - (LAT + 2);
        if (q < 0) begin
            den_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1;
            h2 = 0; v2 = 0;
        end else begin
            h2    = q % ht;
            v2    = (q / ht) % vt;
            den_e = (h2 < HA) && (v2 < VA);
            hs_e  = !((h2 >= HA + HF) && (h2 < HA + HF + HS));
            vs_e  = !((v2 >= VA + VF) && (v2 < VA + VF + VS));
        end
        re = den_e ? (h2 % 32) : 0;
        ge = den_e ? (v2 % 64) : 0;
        be = den_e ? (31 - (h2 % 32)) : 0;
        chk({p, " den"}, 32'(den), 32'(den_e));
        chk({p, " hsync"}, 32'(hs), 32'(hs_e));
        chk({p, " vsync"}, 32'(vs), 32'(vs_e));
        chk({p, " red"}, 32'(r), 32'(re));
        chk({p, " green"}, 32'(g), 32'(ge));
        chk({p, " blue"}, 32'(b), 32'(be));
    endtask

    task automatic sweep(input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            tick();
            check_inst("d0", n, 480, 8, 4, 43, 272, 8, 4, 12, 2,
                       hc0, vc0, rde0, rx0, ry0, fs0, ls0, hs0, vs0, den0, r0, g0, b0);
            check_inst("d1", n, 480, 8, 4, 43, 272, 8, 4, 12, 4,
                       hc1, vc1, rde1, rx1, ry1, fs1, ls1, hs1, vs1, den1, r1, g1, b1);
            check_inst("ds", n, 16, 2, 3, 3, 6, 2, 2, 2, 3,
                       hcs, vcs, rdes, rxs, rys, fss, lss, hss, vss, dens, rs, gs, bs);
            // Hand-picked window edges of the default raster.
            case (n)
                1:   chk("d0 rd_en first cycle", 32'(rde0), 1);
                3:   chk("d0 den before window", 32'(den0), 0);
                4:   chk("d0 den window start", 32'(den0), 1);
                5:   chk("d1 den before window", 32'(den1), 0);
                6:   chk("d1 den window start", 32'(den1), 1);
                480: chk("d0 rd_en last pixel", 32'(rde0), 1);
                481: chk("d0 rd_en after line", 32'(rde0), 0);
                483: chk("d0 den window end", 32'(den0), 1);
                484: chk("d0 den after window", 32'(den0), 0);
                485: chk("d1 den window end", 32'(den1), 1);
                486: chk("d1 den after window", 32'(den1), 0);
                491: chk("d0 hsync before pulse", 32'(hs0), 1);
                492: chk("d0 hsync pulse start", 32'(hs0), 0);
                495: chk("d0 hsync pulse end", 32'(hs0), 0);
                496: chk("d0 hsync after pulse", 32'(hs0), 1);
                default: ;
            endcase
        end
    endtask

    task automatic wait_ds(input int h, input int v, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (int'(hcs) == h && int'(vcs) == v) found = 1'b1;
            else tick();
        end
        if (int'(hcs) == h && int'(vcs) == v) found = 1'b1;
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL wait_ds: position (%0d,%0d) not reached within %0d clocks", h, v, budget);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        repeat (3) tick();
        chk_idle("reset d0", hc0, vc0, rde0, rx0, ry0, fs0, ls0, hs0, vs0, den0, r0, g0, b0);
        chk_idle("reset d1", hc1, vc1, rde1, rx1, ry1, fs1, ls1, hs1, vs1, den1, r1, g1, b1);
        chk_idle("reset ds", hcs, vcs, rdes, rxs, rys, fss, lss, hss, vss, dens, rs, gs, bs);

        // Run from reset: two default lines, four small frames.
        reset = 1'b0;
        sweep(1200);

        // Drop enable mid-line (ds at h=10,v=3; d0 at h=164,v=2, d1 likewise, all inside the active area).
        wait_ds(10, 3, 400);
        en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("disable k=%0d ds hcount", k), 32'(hcs), 0);
            chk($sformatf("disable k=%0d ds vcount", k), 32'(vcs), 0);
            chk($sformatf("disable k=%0d d0 hcount", k), 32'(hc0), 0);
            chk($sformatf("disable k=%0d d0 vcount", k), 32'(vc0), 0);
            chk($sformatf("disable k=%0d d0 rd_en", k), 32'(rde0), 0);
            chk($sformatf("disable k=%0d ds rd_en", k), 32'(rdes), 0);
            chk($sformatf("disable k=%0d ds frame_start", k), 32'(fss), 0);
            chk($sformatf("disable k=%0d ds line_start", k), 32'(lss), 0);
            chk($sformatf("disable k=%0d d0 den", k), 32'(den0), 32'(k < 4));
            chk($sformatf("disable k=%0d d1 den", k), 32'(den1), 32'(k < 6));
            chk($sformatf("disable k=%0d ds den", k), 32'(dens), 32'(k < 5));
            if (k >= 5) begin
                chk($sformatf("disable k=%0d ds rgb", k), {16'd0, rs, gs, bs}, 0);
                chk($sformatf("disable k=%0d ds hsync", k), 32'(hss), 1);
            end
        end

        // Re-enable: raster restarts at (0,0) with frame_start on the next clock.
        en = 1'b1;
        sweep(600);

        // Reset mid-frame (ds at h=8,v=4, pins showing an active pixel).
        wait_ds(8, 4, 400);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_idle($sformatf("midreset k=%0d d0", k), hc0, vc0, rde0, rx0, ry0, fs0, ls0, hs0, vs0, den0, r0, g0, b0);
            chk_idle($sformatf("midreset k=%0d d1", k), hc1, vc1, rde1, rx1, ry1, fs1, ls1, hs1, vs1, den1, r1, g1, b1);
            chk_idle($sformatf("midreset k=%0d ds", k), hcs, vcs, rdes, rxs, rys, fss, lss, hss, vss, dens, rs, gs, bs);
        end
        reset = 1'b0;
        sweep(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_panel_timing_gen.md
Name: lcd_panel_timing_gen

Overview:
- Generates the LCD panel raster (HSYNC, VSYNC, DEN) and the per-pixel read requests into the VDP-to-LCD line buffer.
- Drives the panel RGB pins with the line-buffer data, aligned to the read latency.
- Exposes its raw 11-bit H/V counters so the debug probe can trigger on them, the same way it triggers on the VDP VGA counters.
- Sits between the line buffer (reader side) and the top-level LCD_* pins.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, HSYNC pulse width (clocks)
- H_BP, 43, horizontal back porch (clocks); H_TOTAL = sum = 535
- V_ACTIVE, 272, visible lines
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, VSYNC width (lines)
- V_BP, 12, vertical back porch (lines); V_TOTAL = sum = 296
- RD_LAT, 2, line-buffer read latency (clocks, 1..4)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  raster run; low = hold/idle
- hcount  out  11  horizontal counter, 0..H_TOTAL-1
- vcount  out  11  vertical counter, 0..V_TOTAL-1
- rd_en  out  1  line-buffer read strobe
- rd_x  out  10  pixel column to read
- rd_y  out  9  pixel row to read
- pix_r  in  5  line-buffer red, valid RD_LAT clocks after rd_en
- pix_g  in  6  line-buffer green
- pix_b  in  5  line-buffer blue
- frame_start  out  1  one-clock pulse, first clock of each frame
- line_start  out  1  one-clock pulse, first clock of each line
- lcd_hsync  out  1  active low
- lcd_vsync  out  1  active low
- lcd_den  out  1  active high data enable
- lcd_r  out  5  panel red
- lcd_g  out  6  panel green
- lcd_b  out  5  panel blue

Behaviour:
- Reset values: hcount=0, vcount=0, rd_en=0, rd_x=0, rd_y=0, frame_start=0, line_start=0, lcd_hsync=1, lcd_vsync=1, lcd_den=0, lcd_rgb=0. The delay pipeline is cleared. Reset takes effect on the next edge regardless of raster position, including mid-frame.
- Counter stage:
  - Cycle c=0 is the first clock after reset deasserts with enable=1.
  - hcount increments every clock and wraps H_TOTAL-1 -> 0.
  - vcount increments when hcount wraps, and wraps V_TOTAL-1 -> 0.
- Stage 1 (registered from counter stage):
  - active = hcount<H_ACTIVE && vcount<V_ACTIVE.
  - rd_en=active; rd_x=hcount[9:0]; rd_y=vcount[8:0] (x/y hold last value when inactive).
  - frame_start = (h==0 && v==0); line_start = (h==0).
  - hs_raw low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw low when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Output stage:
  - hs_raw, vs_raw and active are delayed RD_LAT+1 clocks after stage 1.
  - lcd_* are registered together with pix_* sampled at stage 1+RD_LAT.
  - Counter-to-pin latency = RD_LAT+2 clocks.
  - RGB is forced to 0 whenever delayed den=0.
- enable low:
  - Counters are held at 0 and rd_en is forced 0.
  - Pipeline inputs are idle (sync high, den 0) and drain naturally, so the pins go idle RD_LAT+2 clocks later.
  - On re-enable, the raster restarts at (0,0) and frame_start fires.
- Simultaneous reset and enable: reset wins.
- Parameter elaboration check: H_TOTAL<2048, V_TOTAL<2048, H_ACTIVE<=1024, V_ACTIVE<=512.

Decomposition:
- Package lcd_timing_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - the sync start/end localparams
  - typedef rgb565_t {r[4:0], g[5:0], b[4:0]}
- One sub-module, lcd_ctrl_delay: a parameterised-depth shift register for {hs, vs, den}. Its reset value is {1,1,0}.

Test Plan:
- Reset release with enable=1 and defaults -> rd_en high in cycles 1..480; lcd_den high in cycles 4..483 (480 clocks); lcd_hsync low in cycles 492..495.
- Run one full frame -> frame_start pulses exactly every 158360 clocks (535×296); line_start pulses every 535 clocks; lcd_vsync is low for lines 280..283 (4×535 clocks), with edges aligned to lcd_hsync line boundaries + 4 clocks.
- Feed pix = {r=rd_x[4:0], g=rd_y[5:0], b=~rd_x[4:0]} through an RD_LAT delay model -> every lcd_den=1 clock shows matching colour for its (x,y); lcd_rgb=0 whenever lcd_den=0.
- Drop enable mid-line at hcount=200, vcount=100 -> hcount=vcount=0 held; rd_en=0 next clock; lcd_den=0 by 4 clocks. Re-enable -> frame_start the next clock, and the raster restarts at (0,0).
- Assert reset mid-frame at hcount=300, vcount=150 -> next edge: all outputs at their reset values, with no residual den pulse.
- Rebuild with RD_LAT=4 and repeat the first and third scenarios -> den window shifts to cycles 6..485, and data alignment still passes.
